// File: rtl/sext_pipe.sv
// Two-stage valid/ready pipeline that masks a raw field to one of four widths
// and zero- or sign-extends it to OUT_W bits, counting delivered results.
module sext_pipe #(
   parameter int unsigned IN_W  = 11,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned W0    = 5,
   parameter int unsigned W1    = 6,
   parameter int unsigned W2    = 9,
   parameter int unsigned W3    = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_zext,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_neg,
   output logic [15:0]      xfer_cnt
);

   localparam int unsigned CNT_W = 16;

   // Elaboration-time parameter legality checks.
   if (IN_W > OUT_W) begin : g_bad_in_w
      $error("sext_pipe: IN_W must not exceed OUT_W");
   end
   if (W0 < 1 || W0 > IN_W) begin : g_bad_w0
      $error("sext_pipe: W0 out of range");
   end
   if (W1 < 1 || W1 > IN_W) begin : g_bad_w1
      $error("sext_pipe: W1 out of range");
   end
   if (W2 < 1 || W2 > IN_W) begin : g_bad_w2
      $error("sext_pipe: W2 out of range");
   end
   if (W3 < 1 || W3 > IN_W) begin : g_bad_w3
      $error("sext_pipe: W3 out of range");
   end

   function automatic int unsigned sel_width(input logic [1:0] sel);
      case (sel)
         2'd0:    return W0;
         2'd1:    return W1;
         2'd2:    return W2;
         default: return W3;
      endcase
   endfunction

   logic             a_valid;
   logic [IN_W-1:0]  a_data;
   logic [1:0]       a_sel;
   logic             a_zext;
   logic             adv_a;
   logic             adv_b;
   logic [IN_W-1:0]  masked;
   logic [OUT_W-1:0] ext;
   logic             sign;
   int unsigned      wk_in;
   int unsigned      wk_a;

   assign adv_b    = !out_valid || out_ready;
   assign adv_a    = !a_valid || adv_b;
   assign in_ready = adv_a && !reset;

   // Clear field bits above the selected width before they enter stage A.
   always_comb begin
      masked = '0;
      wk_in  = sel_width(in_sel);
      for (int unsigned i = 0; i < IN_W; i++) begin
         if (i < wk_in) masked[i] = in_data[i];
      end
   end

   // Stage A bits above wk are already zero, so only the sign fill is added.
   always_comb begin
      sign = 1'b0;
      wk_a = sel_width(a_sel);
      ext  = OUT_W'(a_data);
      for (int unsigned i = 0; i < IN_W; i++) begin
         if (i + 1 == wk_a) sign = a_data[i];
      end
      for (int unsigned i = 0; i < OUT_W; i++) begin
         if (i >= wk_a && sign && !a_zext) ext[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_valid   <= 1'b0;
         a_data    <= '0;
         a_sel     <= '0;
         a_zext    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_neg   <= 1'b0;
         xfer_cnt  <= '0;
      end else begin
         if (adv_a) begin
            a_valid <= in_valid;
            if (in_valid) begin
               a_data <= masked;
               a_sel  <= in_sel;
               a_zext <= in_zext;
            end
         end
         if (adv_b) begin
            out_valid <= a_valid;
            if (a_valid) begin
               out_data <= ext;
               out_neg  <= ext[OUT_W-1];
            end
         end
         if (out_valid && out_ready) xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/sext_pipe.md
SEXT_PIPE -- requirements
Module: sext_pipe

Interface
REQ-001 Parameter IN_W, default 11: width of raw field input; SHALL satisfy IN_W <= OUT_W.
REQ-002 Parameter OUT_W, default 16: width of extended output.
REQ-003 Parameters W0/W1/W2/W3, defaults 5/6/9/11: field widths selected by in_sel 0..3; each SHALL satisfy 1 <= Wk <= IN_W, else elaboration error.
REQ-004 Clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers a field.
REQ-007 in_ready  output  1  block accepts the field this cycle.
REQ-008 in_data  input  IN_W  raw field, LSB-aligned; bits above selected width are don't-care.
REQ-009 in_sel  input  2  field width select (W0..W3).
REQ-010 in_zext  input  1  1 = zero-extend, 0 = sign-extend.
REQ-011 out_valid  output  1  out_data holds a result.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  OUT_W  extended value.
REQ-014 out_neg  output  1  copy of out_data[OUT_W-1].
REQ-015 xfer_cnt  output  16  count of completed output handshakes.

Function
REQ-016 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-017 Block SHALL be a two-stage pipeline: stage A registers masked field, width select and zext; stage B registers extended result and drives out_*.
REQ-018 adv_B = !B_valid || out_ready; adv_A = !A_valid || adv_B; in_ready SHALL equal adv_A && !Reset (combinational, no bubble at full throughput).
REQ-019 Latency SHALL be 2 cycles from input handshake to out_valid with no stall; sustained throughput SHALL be 1 result/cycle while out_ready=1.
REQ-020 Stage A SHALL clear in_data bits [IN_W-1:Wk] for selected width Wk before registering.
REQ-021 Stage B SHALL output bits [Wk-1:0] of the field unchanged; bits [OUT_W-1:Wk] SHALL be 0 if zext=1, else replicas of bit Wk-1.
REQ-022 Wk = OUT_W SHALL pass the field through unchanged regardless of zext.
REQ-023 While out_valid && !out_ready, out_data, out_neg and out_valid SHALL hold stable; stage A SHALL hold if also valid; in_ready SHALL be 0 when both stages full.
REQ-024 Stage B SHALL load from stage A on adv_B; B_valid SHALL clear on output handshake when A_valid=0.
REQ-025 Simultaneous output handshake and input handshake with both stages full SHALL shift A->B and load A in same cycle, no data loss or duplication.
REQ-026 xfer_cnt SHALL increment by 1 on each output handshake, wrapping 0xFFFF -> 0x0000.
REQ-027 No transaction SHALL be dropped, reordered or duplicated.

Reset
REQ-028 On Clk edge with Reset=1: A_valid=0, B_valid=0, out_valid=0, out_data=0, out_neg=0, xfer_cnt=0.
REQ-029 Reset SHALL dominate any simultaneous handshake; in-flight transactions SHALL be discarded and not counted.
REQ-030 in_ready SHALL be 0 while Reset=1 and 1 on first cycle after Reset deasserts.

Verification
REQ-031 sel=0, zext=0, in_data=0x010 -> after 2 cycles out_data=0xFFF0, out_neg=1; sel=1, zext=0, in_data=0x7E0 -> 0xFFE0 (upper garbage ignored).
REQ-032 sel=2, in_data=0x1FF: zext=1 -> 0x01FF, out_neg=0; zext=0 -> 0xFFFF; sel=3, zext=0, in_data=0x3FF -> 0x03FF.
REQ-033 Stream 8 back-to-back inputs, out_ready=1 -> 8 results on consecutive cycles starting 2 cycles after first, in order, xfer_cnt=8.
REQ-034 out_ready=0 for 5 cycles with 3 inputs offered -> exactly 2 accepted, in_ready=0 thereafter, out_data stable; release -> all 3 delivered in order.
REQ-035 Preload xfer_cnt path to 0xFFFF (65535 handshakes) -> next handshake gives xfer_cnt=0x0000.
REQ-036 Reset asserted with both stages full and out_ready=1 -> next cycle out_valid=0, out_data=0, xfer_cnt=0, in_ready=0; after deassert first new input emerges 2 cycles later.
